// File: rtl/quadra_pipe_if.sv
// Handshake bus for quadra_pipe: one operand beat in, one result beat out.
//   in_valid/in_ready : input beat handshake
//   in_x              : unsigned u0.X_FRAC abscissa
//   in_a/in_b/in_c    : signed coefficients
//   out_valid/out_ready : result beat handshake
//   out_y/out_sat     : result and overflow flag
interface quadra_pipe_if #(
  parameter int X_FRAC = 17,
  parameter int COEF_W = 32,
  parameter int Y_W    = 25
);
  logic              in_valid;
  logic              in_ready;
  logic [X_FRAC-1:0] in_x;
  logic [COEF_W-1:0] in_a;
  logic [COEF_W-1:0] in_b;
  logic [COEF_W-1:0] in_c;
  logic              out_valid;
  logic              out_ready;
  logic [Y_W-1:0]    out_y;
  logic              out_sat;

  modport master (
    output in_valid, in_x, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_y, out_sat
  );
  modport slave (
    input  in_valid, in_x, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_y, out_sat
  );
endinterface

// File: rtl/quadra_pipe.sv
// Three-stage pipelined quadratic evaluator: y = a + b*x + c*x^2.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : quadra_pipe_if slave (input beat, result beat)
// S1: operands + exact x^2; S2: exact b*x, c*x^2; S3: reduced/saturated sum.
// Each stage stalls independently so the pipe holds three beats under backpressure.
module quadra_pipe #(
  parameter int X_FRAC    = 17,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 30,
  parameter int Y_W       = 25,
  parameter int Y_FRAC    = 23,
  parameter int ROUND     = 0,
  parameter int SAT       = 1
) (
  input logic          clk,
  input logic          rst,
  quadra_pipe_if.slave bus
);
  localparam int X2_W  = 2 * X_FRAC;
  localparam int BX_W  = COEF_W + X_FRAC + 1;
  localparam int CX_W  = COEF_W + X2_W + 1;
  // three terms each bounded by 2^(COEF_W-1+X2_W): two spare bits, one extra margin
  localparam int SUM_W = COEF_W + X2_W + 3;
  localparam int SH    = COEF_FRAC + X2_W - Y_FRAC;

  localparam logic signed [SUM_W-1:0] HALF  = (ROUND != 0) ? (SUM_W'(1) << (SH - 1)) : '0;
  localparam logic signed [SUM_W-1:0] Y_MAX = (SUM_W'(1) << (Y_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] Y_MIN = -(SUM_W'(1) << (Y_W - 1));

  // handshake: each stage loads when upstream is valid and it is empty or draining
  logic [3:1] vld_pipe;
  logic       ld1, ld2, ld3, adv3;

  assign adv3         = vld_pipe[3] & bus.out_ready;
  assign ld3          = vld_pipe[2] & (~vld_pipe[3] | adv3);
  assign ld2          = vld_pipe[1] & (~vld_pipe[2] | ld3);
  assign bus.in_ready = ~vld_pipe[1] | ld2;
  assign ld1          = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= ld1 | (vld_pipe[1] & ~ld2);
      vld_pipe[2] <= ld2 | (vld_pipe[2] & ~ld3);
      vld_pipe[3] <= ld3 | (vld_pipe[3] & ~adv3);
    end
  end

  // S1: operands and exact x^2
  logic        [X2_W-1:0]   x_w, x_sq;
  logic        [X_FRAC-1:0] s1_x;
  logic        [X2_W-1:0]   s1_x2;
  logic signed [COEF_W-1:0] s1_a, s1_b, s1_c;

  assign x_w  = X2_W'(bus.in_x);
  assign x_sq = x_w * x_w;

  always_ff @(posedge clk) begin
    if (ld1) begin
      s1_x  <= bus.in_x;
      s1_x2 <= x_sq;
      s1_a  <= $signed(bus.in_a);
      s1_b  <= $signed(bus.in_b);
      s1_c  <= $signed(bus.in_c);
    end
  end

  // S2: exact products; x terms are zero-extended so they stay non-negative
  logic signed [BX_W-1:0]   b_e, xb_e, bx;
  logic signed [CX_W-1:0]   c_e, x2_e, cx;
  logic signed [COEF_W-1:0] s2_a;
  logic signed [BX_W-1:0]   s2_bx;
  logic signed [CX_W-1:0]   s2_cx;

  assign b_e  = BX_W'(s1_b);
  assign xb_e = $signed(BX_W'(s1_x));
  assign bx   = b_e * xb_e;
  assign c_e  = CX_W'(s1_c);
  assign x2_e = $signed(CX_W'(s1_x2));
  assign cx   = c_e * x2_e;

  always_ff @(posedge clk) begin
    if (ld2) begin
      s2_a  <= s1_a;
      s2_bx <= bx;
      s2_cx <= cx;
    end
  end

  // S3: align all terms to COEF_FRAC + 2*X_FRAC, round, reduce, range-check.
  // The range check runs after rounding so a rounding carry past the max bound
  // is reported as overflow.
  logic signed [SUM_W-1:0] sum, rsum, red;
  logic                    ovf_hi, ovf_lo;
  logic        [Y_W-1:0]   y_nxt;
  logic        [Y_W-1:0]   s3_y;
  logic                    s3_sat;

  assign sum    = (SUM_W'(s2_a) <<< X2_W) + (SUM_W'(s2_bx) <<< X_FRAC) + SUM_W'(s2_cx);
  assign rsum   = sum + HALF;
  assign red    = rsum >>> SH;
  assign ovf_hi = red > Y_MAX;
  assign ovf_lo = red < Y_MIN;

  always_comb begin
    y_nxt = red[Y_W-1:0];
    if (SAT != 0) begin
      if (ovf_hi)      y_nxt = Y_MAX[Y_W-1:0];
      else if (ovf_lo) y_nxt = Y_MIN[Y_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ld3) begin
      s3_y   <= y_nxt;
      s3_sat <= ovf_hi | ovf_lo;
    end
  end

  // S3 payload is never reset, so outputs are masked while no beat is present
  assign bus.out_valid = vld_pipe[3];
  assign bus.out_y     = vld_pipe[3] ? s3_y : '0;
  assign bus.out_sat   = vld_pipe[3] & s3_sat;
endmodule

// File: doc/quadra_pipe.md
QUADRA_PIPE -- requirements
Module: quadra_pipe

Interface
REQ-001 SHALL have parameter X_FRAC, default 17: input x is unsigned u0.X_FRAC, width X_FRAC.
REQ-002 SHALL have parameter COEF_W, default 32: width of signed coefficients a, b, c.
REQ-003 SHALL have parameter COEF_FRAC, default 30: fraction bits of a, b, c (s(COEF_W-COEF_FRAC).COEF_FRAC).
REQ-004 SHALL have parameter Y_W, default 25: signed output width.
REQ-005 SHALL have parameter Y_FRAC, default 23: output fraction bits; Y_FRAC <= COEF_FRAC.
REQ-006 SHALL have parameter ROUND, default 0: 0 = truncate toward -inf, 1 = round half up.
REQ-007 SHALL have parameter SAT, default 1: 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-008 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port in_valid, input, 1: input beat offered.
REQ-011 SHALL have port in_ready, output, 1: block accepts beat this cycle.
REQ-012 SHALL have ports in_x (input, X_FRAC), in_a, in_b, in_c (input, COEF_W each): operands of one beat.
REQ-013 SHALL have port out_valid, output, 1: result beat present.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-015 SHALL have port out_y, output, Y_W: f(x) = a + b*x + c*x^2 in sY_W.Y_FRAC.
REQ-016 SHALL have port out_sat, output, 1: overflow detected for this beat (SAT=1 clamped; SAT=0 wrapped).

Function
REQ-017 Beat transfers at input when in_valid & in_ready; at output when out_valid & out_ready.
REQ-018 Three pipeline stages: S1 registers operands and x^2 (exact, 2*X_FRAC fraction bits); S2 registers b*x and c*x^2 (exact); S3 registers the sum after reduction and saturation.
REQ-019 Each stage has a valid bit; stage k loads when its predecessor is valid and (stage k empty or stage k's content advances the same cycle).
REQ-020 in_ready = !S1_valid | S1 advances; out_valid = S3_valid; no combinational path from in_valid to in_ready.
REQ-021 Latency with out_ready held high: result for beat accepted in cycle n appears with out_valid in cycle n+3; throughput one beat per cycle.
REQ-022 Under out_ready low, the pipeline holds up to 3 beats; out_y/out_sat stay stable while out_valid & !out_ready; in_ready falls once all stages are full.
REQ-023 Beats leave in acceptance order; none dropped or duplicated.
REQ-024 Sum computed exactly at COEF_FRAC + 2*X_FRAC fraction bits with enough integer bits to never overflow internally (>= COEF_W + 2).
REQ-025 Reduction to Y_FRAC: ROUND=0 arithmetic right shift; ROUND=1 adds 2^(shift-1) before shift.
REQ-026 After reduction, value outside [-2^(Y_W-1), 2^(Y_W-1)-1] LSBs: SAT=1 clamps to bound, SAT=0 keeps low Y_W bits; out_sat=1 in both cases, else 0.
REQ-027 Rounding carry that overflows (e.g. max positive + half LSB) SHALL be treated as overflow per REQ-026.
REQ-028 Stage payload registers SHALL load only when the stage loads; payload of an empty stage is don't-care internally but out_y SHALL be 0 when out_valid=0.

Reset
REQ-029 rst high clears all stage valid bits immediately; out_valid=0, out_y=0, out_sat=0, in_ready=1 after release.
REQ-030 Reset mid-operation discards all in-flight beats; first beat after release has full 3-cycle latency.

Verification
REQ-031 Defaults, x=0x10000 (0.5), a=0x10000000 (0.25), b=c=0x40000000 (1.0), out_ready=1 -> out_y=0x0800000 (1.0), out_sat=0, 3 cycles after acceptance.
REQ-032 a=b=c=0x7FFFFFFF, x=0x1FFFF -> SAT=1: out_y=0x0FFFFFF, out_sat=1; a=b=c=0x80000000 -> out_y=0x1000000, out_sat=1; SAT=0 same stimulus -> wrapped low 25 bits, out_sat=1.
REQ-033 a=0x00000040 (2^-24), b=c=0, x=0 -> ROUND=0: out_y=0; ROUND=1: out_y=0x0000001.
REQ-034 Stream 6 beats back-to-back, out_ready low cycles 2-6 -> in_ready low after 3 beats held, out_y stable while stalled, all 6 results in order, none lost.
REQ-035 Assert rst with 3 beats in flight -> out_valid=0 and out_y=0 same cycle; no stale beat after release; next beat emerges 3 cycles after acceptance.
REQ-036 Random operands, random in_valid/out_ready, each parameter set (ROUND 0/1, SAT 0/1, X_FRAC 12) -> every out_y/out_sat equals bit-exact reference model.
